sha256_uart_host: RTL and testbench

Host-side controller for the UART-attached SHA-256 engine. It takes one pre-padded 64-byte message block from a local byte stream and drives it out through a UART transmitter. It then collects the 32 digest bytes returned on a UART receiver and presents them as a 256-bit word. It is the requester end of the byte protocol that the SHA-256 engine's UART front end consumes and answers.

---
 rtl/sha256_host_pkg.sv | 19 +
 rtl/sha256_uart_host.sv | 175 +++++++++++++++++
 tb/tb_sha256_uart_host.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_host_pkg.sv
// Shared types and constants for the SHA-256 UART host controller.
package sha256_host_pkg;

  localparam int unsigned BlockBytesDefault  = 64;
  localparam int unsigned DigestBytesDefault = 32;
  localparam int unsigned TxCntW             = 6;
  localparam int unsigned RxCntW             = 5;
  localparam int unsigned DigestW            = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_WAIT_TX,
    S_RECV,
    S_DONE
  } host_state_e;

endpackage

// File: rtl/sha256_uart_host.sv
// Requester side of the SHA-256 UART byte protocol: streams one padded 64-byte
// block out through a UART transmitter, then shifts the 32 returned digest bytes
// into a 256-bit word. Optional receive timeout: define SHA256_HOST_TIMEOUT_EN.
module sha256_uart_host
  import sha256_host_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES    = BlockBytesDefault,
  parameter int unsigned DIGEST_BYTES   = DigestBytesDefault,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               s_valid,
  input  logic [7:0]         s_data,
  output logic               s_ready,
  output logic               tx_dv_out,
  output logic [7:0]         tx_byte_out,
  input  logic               tx_active_in,
  input  logic               tx_done_in,
  input  logic               rx_dv_in,
  input  logic [7:0]         rx_byte_in,
  output logic               busy,
  output logic [DigestW-1:0] digest_out,
  output logic               digest_valid,
  output logic               err_timeout
);

  host_state_e         state_q, state_d;
  logic [TxCntW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [RxCntW-1:0]   rx_cnt_q, rx_cnt_d;
  logic                rx_full_q, rx_full_d;
  logic                start_pend_q, start_pend_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic [DigestW-1:0]  digest_q, digest_d;
  logic                s_ready_q, tx_dv_q, busy_q, digest_valid_q;
  logic                timeout_hit;

`ifdef SHA256_HOST_TIMEOUT_EN
  localparam int unsigned ToCntW = $clog2(TIMEOUT_CYCLES);

  logic [ToCntW-1:0] to_cnt_q, to_cnt_d;
  logic              err_q;

  // Idle-cycle counter in S_RECV; any received byte restarts the window.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == S_RECV && !rx_dv_in) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == S_RECV) && !rx_dv_in &&
                       (to_cnt_d == ToCntW'(TIMEOUT_CYCLES - 1));

  // Timeout counter and sticky error flag (cleared by an accepted start).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      if (state_q == S_IDLE && start) begin
        err_q <= 1'b0;
      end else if (timeout_hit && !rx_full_q) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_timeout = err_q;
`else
  // No counter: S_RECV waits for the full digest; parameter kept referenced.
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES != 0);
  assign err_timeout = 1'b0;
`endif

  // Next-state, counters and data path.
  always_comb begin
    state_d      = state_q;
    tx_cnt_d     = tx_cnt_q;
    rx_cnt_d     = rx_cnt_q;
    rx_full_d    = rx_full_q;
    start_pend_d = start_pend_q;
    tx_byte_d    = tx_byte_q;
    digest_d     = digest_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_cnt_d  = '0;
          rx_cnt_d  = '0;
          rx_full_d = 1'b0;
        end
        // Hold a start request until the transmitter is free.
        if (start || start_pend_q) begin
          if (tx_active_in) begin
            start_pend_d = 1'b1;
          end else begin
            start_pend_d = 1'b0;
            state_d      = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (s_valid) begin
          tx_byte_d = s_data;
          state_d   = S_SEND;
        end
      end
      S_SEND: state_d = S_WAIT_TX;
      S_WAIT_TX: begin
        if (tx_done_in) begin
          if (tx_cnt_q == TxCntW'(BLOCK_BYTES - 1)) begin
            state_d = S_RECV;
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
            state_d  = S_FETCH;
          end
        end
      end
      S_RECV: begin
        // rx_full_q delays the exit by one cycle after the last byte.
        if (rx_full_q || timeout_hit) begin
          state_d = S_DONE;
        end else if (rx_dv_in) begin
          digest_d = {digest_q[DigestW-9:0], rx_byte_in};
          if (rx_cnt_q == RxCntW'(DIGEST_BYTES - 1)) begin
            rx_full_d = 1'b1;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      tx_cnt_q       <= '0;
      rx_cnt_q       <= '0;
      rx_full_q      <= 1'b0;
      start_pend_q   <= 1'b0;
      tx_byte_q      <= 8'h00;
      digest_q       <= '0;
      s_ready_q      <= 1'b0;
      tx_dv_q        <= 1'b0;
      busy_q         <= 1'b0;
      digest_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tx_cnt_q       <= tx_cnt_d;
      rx_cnt_q       <= rx_cnt_d;
      rx_full_q      <= rx_full_d;
      start_pend_q   <= start_pend_d;
      tx_byte_q      <= tx_byte_d;
      digest_q       <= digest_d;
      s_ready_q      <= (state_d == S_FETCH);
      tx_dv_q        <= (state_d == S_SEND);
      busy_q         <= (state_d != S_IDLE);
      digest_valid_q <= (state_d == S_DONE);
    end
  end

  assign s_ready      = s_ready_q;
  assign tx_dv_out    = tx_dv_q;
  assign tx_byte_out  = tx_byte_q;
  assign busy         = busy_q;
  assign digest_out   = digest_q;
  assign digest_valid = digest_valid_q;

endmodule

// File: tb/tb_sha256_uart_host.sv
// Self-checking bench for sha256_uart_host: UART transmitter model, byte
// scoreboard on the TX side and digest scoreboard on digest_valid.
module tb_sha256_uart_host;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, s_valid, s_ready;
  logic [7:0]   s_data;
  logic         tx_dv_out, tx_active_in, tx_done_in;
  logic [7:0]   tx_byte_out;
  logic         rx_dv_in;
  logic [7:0]   rx_byte_in;
  logic         busy, digest_valid, err_timeout;
  logic [255:0] digest_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   tx_q[$];
  logic [255:0] dig_q[$];
  logic [7:0]   blk[64];
  logic [255:0] model_digest;
  int           cyc = 0;
  int           last_rx_cyc = 0;
  int           exp_lat = 2;
  int           tx_pulses = 0;
  int           dv_seen = 0;

  localparam logic [255:0] AbcDigest =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  sha256_uart_host #(
    .BLOCK_BYTES   (64),
    .DIGEST_BYTES  (32),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .tx_dv_out   (tx_dv_out),
    .tx_byte_out (tx_byte_out),
    .tx_active_in(tx_active_in),
    .tx_done_in  (tx_done_in),
    .rx_dv_in    (rx_dv_in),
    .rx_byte_in  (rx_byte_in),
    .busy        (busy),
    .digest_out  (digest_out),
    .digest_valid(digest_valid),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // TX monitor: every tx_dv_out pulse pops the scoreboard.
  initial begin
    logic prev_dv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_dv) check("tx_dv_pulse", {255'b0, tx_dv_out}, 256'd0);
      if (tx_dv_out && !prev_dv) begin
        tx_pulses++;
        if (tx_q.size() == 0) check("tx_unexpected", {255'b0, tx_dv_out}, 256'd0);
        else check("tx_byte", {248'b0, tx_byte_out}, {248'b0, tx_q.pop_front()});
      end
      prev_dv = tx_dv_out;
    end
  end

  // UART transmitter model: busy for a few cycles, then a tx_done pulse.
  initial begin
    tx_active_in = 1'b0;
    tx_done_in   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_dv_out) begin
        tx_active_in = 1'b1;
        repeat (3) @(posedge clk);
        #1 tx_done_in = 1'b1;
        @(posedge clk);
        #1 tx_done_in = 1'b0;
        tx_active_in = 1'b0;
      end
    end
  end

  // Digest monitor: digest_valid pops the expected digest and checks latency.
  initial begin
    logic prev_dv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_dv) check("dv_pulse", {255'b0, digest_valid}, 256'd0);
      if (digest_valid && !prev_dv) begin
        dv_seen++;
        if (dig_q.size() == 0) begin
          check("dv_unexpected", {255'b0, digest_valid}, 256'd0);
        end else begin
          check("digest", digest_out, dig_q.pop_front());
          check("dv_latency", 256'(cyc - last_rx_cyc), 256'(exp_lat));
        end
      end
      prev_dv = digest_valid;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_sready();
    for (int c = 0; c < 200 && !s_ready; c++) begin
      @(posedge clk);
      #1;
    end
    if (!s_ready) check("s_ready_wait", {255'b0, s_ready}, 256'd1);
  endtask

  task automatic run_txn(input int stall_at, input int busy_at, input bit stray,
                         input logic [255:0] dg, input int resp_n, input int lat,
                         input bit expect_dv);
    int base_tx, base_dv, low;
    logic [7:0] b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("err_clear", {255'b0, err_timeout}, 256'd0);
    base_tx = tx_pulses;
    if (stray) begin
      wait_sready();
      rx_dv_in = 1'b1;
      rx_byte_in = 8'hAA;
      @(posedge clk);
      #1 rx_dv_in = 1'b0;
      check("stray_hold", digest_out, model_digest);
    end
    for (int i = 0; i < 64; i++) begin
      if (i == stall_at) begin
        wait_sready();
        base_dv = tx_pulses;
        low = 0;
        repeat (50) begin
          @(posedge clk);
          #1;
          if (!s_ready) low++;
        end
        check("bp_ready_low", 256'(low), 256'd0);
        check("bp_no_tx", 256'(tx_pulses), 256'(base_dv));
      end
      s_valid = 1'b1;
      s_data  = blk[i];
      if (i == busy_at) start = 1'b1;
      wait_sready();
      tx_q.push_back(blk[i]);
      @(posedge clk);
      #1 s_valid = 1'b0;
      start = 1'b0;
    end
    for (int c = 0; c < 200 && (tx_pulses != base_tx + 64 || tx_active_in); c++) begin
      @(posedge clk);
      #1;
    end
    check("tx_count", 256'(tx_pulses - base_tx), 256'd64);
    check("txq_empty", 256'(tx_q.size()), 256'd0);
    repeat (3) @(posedge clk);
    #1;
    check("busy_recv", {255'b0, busy}, 256'd1);
    base_dv = dv_seen;
    exp_lat = lat;
    for (int k = 0; k < resp_n; k++) begin
      b = dg[255 - 8 * k -: 8];
      model_digest = {model_digest[247:0], b};
      rx_dv_in = 1'b1;
      rx_byte_in = b;
      last_rx_cyc = cyc;
      if (k == resp_n - 1 && expect_dv) dig_q.push_back(model_digest);
      @(posedge clk);
      #1 rx_dv_in = 1'b0;
      if (k != resp_n - 1) repeat (2) @(posedge clk);
      #1;
    end
    if (expect_dv) begin
      for (int c = 0; c < lat + 20 && dv_seen == base_dv; c++) begin
        @(posedge clk);
        #1;
      end
      check("dv_count", 256'(dv_seen), 256'(base_dv + 1));
      repeat (2) @(posedge clk);
      #1;
      check("idle_busy", {255'b0, busy}, 256'd0);
    end
  endtask

  task automatic check_reset_values();
    check("rst_s_ready", {255'b0, s_ready}, 256'd0);
    check("rst_tx_dv", {255'b0, tx_dv_out}, 256'd0);
    check("rst_busy", {255'b0, busy}, 256'd0);
    check("rst_dv", {255'b0, digest_valid}, 256'd0);
    check("rst_err", {255'b0, err_timeout}, 256'd0);
    check("rst_tx_byte", {248'b0, tx_byte_out}, 256'd0);
    check("rst_digest", digest_out, 256'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    rx_dv_in = 1'b0;
    rx_byte_in = 8'h00;
    model_digest = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Padded "abc" block.
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    blk[0] = 8'h61; blk[1] = 8'h62; blk[2] = 8'h63; blk[3] = 8'h80; blk[63] = 8'h18;
    run_txn(-1, -1, 1'b0, AbcDigest, 32, 2, 1'b1);

    // Backpressure mid-block.
    for (int i = 0; i < 64; i++) blk[i] = 8'($urandom);
    run_txn(20, -1, 1'b0, {8{$urandom}}, 32, 2, 1'b1);

    // Stray RX byte while fetching.
    for (int i = 0; i < 64; i++) blk[i] = 8'($urandom);
    run_txn(-1, -1, 1'b1, {8{$urandom}}, 32, 2, 1'b1);

    // Start pulsed while busy.
    for (int i = 0; i < 64; i++) blk[i] = 8'($urandom);
    run_txn(-1, 10, 1'b0, {8{$urandom}}, 32, 2, 1'b1);

    // Reset after 16 digest bytes.
    for (int i = 0; i < 64; i++) blk[i] = 8'($urandom);
    run_txn(-1, -1, 1'b0, {8{$urandom}}, 16, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    model_digest = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 64; i++) blk[i] = 8'($urandom);
    run_txn(-1, -1, 1'b0, AbcDigest, 32, 2, 1'b1);

`ifdef SHA256_HOST_TIMEOUT_EN
    // Timeout after 5 digest bytes.
    for (int i = 0; i < 64; i++) blk[i] = 8'($urandom);
    run_txn(-1, -1, 1'b0, {8{$urandom}}, 5, 100, 1'b1);
    check("err_set", {255'b0, err_timeout}, 256'd1);
    run_txn(-1, -1, 1'b0, AbcDigest, 32, 2, 1'b1);
`endif

    check("digq_empty", 256'(dig_q.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
